// File: rtl/sam_pkg.sv
// Shared constants and state encoding for the SAM main-memory slice.
package sam_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Wait counter only has to hold LATENCY-1, but never shrinks below one bit.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/sam_mem_array.sv
// Single-port synchronous word RAM; read data is registered on i_re and held.
module sam_mem_array
  import sam_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned DEPTH     = 256,
  parameter string       INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_we,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_idx,
  input  logic [DATA_W-1:0]        i_din,
  output logic [DATA_W-1:0]        o_dout
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_din;
  end

  // Array contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (i_rst)     r_dout <= '0;
    else if (i_re) r_dout <= r_mem[i_idx];
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/sam_memory.sv
// SAM main memory: request/rw access FSM with fixed wait states in front of a word RAM.
module sam_memory
  import sam_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned LATENCY   = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              request,
  input  logic              rw,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_wait
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_width(LATENCY);

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_rw;
  logic [DATA_W-1:0]  r_wdata;
  logic               w_fire;
  logic               w_unused_addr;

  assign w_unused_addr = ^address;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (request)        w_next_state = ST_BUSY;
      ST_BUSY: if (r_cnt == '0)    w_next_state = ST_DONE;
      ST_DONE: if (!request)       w_next_state = ST_IDLE;
      default:                     w_next_state = ST_IDLE;
    endcase
  end

  // Reset gates both the handshake and the array strobes so an aborted access never lands.
  always_comb begin
    mem_wait = 1'b0;
    w_fire   = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_IDLE: mem_wait = request;
        ST_BUSY: begin
          mem_wait = 1'b1;
          w_fire   = (r_cnt == '0);
        end
        default: mem_wait = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rw    <= RW_READ;
      r_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (request) begin
          r_idx   <= address[IDX_W:1];
          r_rw    <= rw;
          r_wdata <= wdata;
          r_cnt   <= CNT_W'(LATENCY - 1);
        end
        ST_BUSY: if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  sam_mem_array #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk    (clk),
    .i_rst  (reset),
    .i_we   (w_fire && (r_rw == RW_WRITE)),
    .i_re   (w_fire && (r_rw == RW_READ)),
    .i_idx  (r_idx),
    .i_din  (r_wdata),
    .o_dout (rdata)
  );

endmodule

// File: tb/tb_sam_memory.sv
// Self-checking bench for sam_memory: fixed vectors, corner sequences, random traffic vs a word model.
module tb_sam_memory;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic        request;
  logic        rw;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        mem_wait;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_mem   [DEPTH];
  bit          m_valid [DEPTH];
  logic [15:0] m_rd;

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl [10];

  sam_memory #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .request  (request),
    .rw       (rw),
    .wdata    (wdata),
    .rdata    (rdata),
    .mem_wait (mem_wait)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [15:0] a);
    return (int'(a) / 2) % DEPTH;
  endfunction

  // One full four-phase access; optional operand scrambling during BUSY and held request after DONE.
  task automatic xact(input logic [15:0] a, input logic r, input logic [15:0] d,
                      input logic [15:0] exp_rd, input int hold, input bit scramble,
                      input string tag);
    int  hi;
    bit  done;
    @(negedge clk);
    address = a; rw = r; wdata = d; request = 1'b1;
    #1 check({tag, " wait_cycle0"}, {15'd0, mem_wait}, 16'd1);
    hi = 1;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(posedge clk); #1;
      if (k == 0 && scramble) begin
        address = a ^ 16'h0002; wdata = ~d; rw = ~r;
      end
      if (mem_wait) hi++;
      else done = 1'b1;
    end
    check({tag, " wait_len"}, 16'(hi), 16'(LATENCY + 1));
    check({tag, " rdata_done"}, rdata, exp_rd);
    for (int h = 0; h < hold; h++) begin
      rw = ~r; wdata = 16'h0BAD; address = a;
      @(posedge clk); #1;
      check({tag, " hold_wait"}, {15'd0, mem_wait}, 16'd0);
      check({tag, " hold_rdata"}, rdata, exp_rd);
    end
    @(negedge clk);
    request = 1'b0;
    @(posedge clk); #1;
    check({tag, " idle_wait"}, {15'd0, mem_wait}, 16'd0);
    check({tag, " idle_rdata"}, rdata, exp_rd);
  endtask

  // Model-driven access: expectation comes from the word model, not the DUT.
  task automatic run(input logic [15:0] a, input logic r, input logic [15:0] d,
                     input int hold, input bit scramble, input string tag);
    int i;
    i = idx_of(a);
    if (r) m_rd = m_mem[i];
    else begin
      m_mem[i] = d;
      m_valid[i] = 1'b1;
    end
    xact(a, r, d, m_rd, hold, scramble, tag);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_rd = 16'h0000;

    tbl[0] = '{16'h0010, 1'b0, 16'hBEEF, 16'h0000};
    tbl[1] = '{16'h0010, 1'b1, 16'h0000, 16'hBEEF};
    tbl[2] = '{16'h0200, 1'b0, 16'h1234, 16'hBEEF};
    tbl[3] = '{16'h0000, 1'b1, 16'h0000, 16'h1234};
    tbl[4] = '{16'h0003, 1'b0, 16'h5678, 16'h1234};
    tbl[5] = '{16'h0002, 1'b1, 16'h0000, 16'h5678};
    tbl[6] = '{16'h01FE, 1'b0, 16'hCAFE, 16'h5678};
    tbl[7] = '{16'hFFFE, 1'b1, 16'h0000, 16'hCAFE};
    tbl[8] = '{16'h0010, 1'b1, 16'h0000, 16'hBEEF};
    tbl[9] = '{16'h0004, 1'b0, 16'h1111, 16'hBEEF};

    // Reset held with request high
    reset = 1'b1; request = 1'b1; rw = 1'b1; address = 16'h0010; wdata = 16'h0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("reset_wait", {15'd0, mem_wait}, 16'd0);
      check("reset_rdata", rdata, 16'h0000);
    end
    @(negedge clk);
    reset = 1'b0; request = 1'b0;
    #1 check("release_wait", {15'd0, mem_wait}, 16'd0);

    // Directed vectors
    for (int v = 0; v < 10; v++) begin
      if (!tbl[v].rw) begin
        m_mem[idx_of(tbl[v].addr)] = tbl[v].wdata;
        m_valid[idx_of(tbl[v].addr)] = 1'b1;
      end else m_rd = tbl[v].exp_rd;
      xact(tbl[v].addr, tbl[v].rw, tbl[v].wdata, tbl[v].exp_rd, 0, 1'b0, $sformatf("tbl%0d", v));
    end

    // Held request: writes offered during hold must not start
    run(16'h0010, 1'b1, 16'h0000, 6, 1'b0, "held");
    run(16'h0010, 1'b1, 16'h0000, 0, 1'b0, "held_after");
    check("held_model", m_rd, 16'hBEEF);

    // Latched operands
    run(16'h0022, 1'b0, 16'h2222, 0, 1'b0, "latch_pre");
    run(16'h0020, 1'b0, 16'h7777, 0, 1'b1, "latch_wr");
    run(16'h0020, 1'b1, 16'h0000, 0, 1'b0, "latch_rd0");
    run(16'h0022, 1'b1, 16'h0000, 0, 1'b0, "latch_rd1");
    run(16'h0022, 1'b1, 16'h0000, 0, 1'b1, "latch_rdscr");

    // Abort a write in its second BUSY cycle
    @(negedge clk);
    address = 16'h0004; rw = 1'b0; wdata = 16'hAAAA; request = 1'b1;
    @(posedge clk); #1;
    check("abort_busy1", {15'd0, mem_wait}, 16'd1);
    @(posedge clk); #1;
    check("abort_busy2", {15'd0, mem_wait}, 16'd1);
    reset = 1'b1;
    #1 check("abort_wait_rst", {15'd0, mem_wait}, 16'd0);
    @(posedge clk); #1;
    check("abort_rdata", rdata, 16'h0000);
    m_rd = 16'h0000;
    @(negedge clk);
    reset = 1'b0; request = 1'b0;
    @(posedge clk); #1;
    check("abort_idle", {15'd0, mem_wait}, 16'd0);
    run(16'h0004, 1'b1, 16'h0000, 0, 1'b0, "abort_rd");
    check("abort_model", m_rd, 16'h1111);

    // Random traffic against the word model
    for (int t = 0; t < 60; t++) begin
      logic [15:0] a;
      logic        r;
      logic [15:0] d;
      a = 16'($urandom);
      r = 1'($urandom % 2);
      d = 16'($urandom);
      if (r && !m_valid[idx_of(a)]) r = 1'b0;
      run(a, r, d, int'($urandom_range(0, 2)), bit'($urandom % 2), $sformatf("rnd%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
